seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed N-digit 7-segment display driver; parametrised successor of the
//  single-digit BCD/hex segment decoder. Holds a double-buffered digit frame, scans one
//  digit per slot with an anti-ghosting blank gap, suppresses leading zeros and drives
//  decimal points. Sits between datapath/display logic and the board's shared-segment pins.
// PARAMETERS
//  DIGITS       4      number of digits scanned, legal 1..8
//  REFRESH_DIV  50000  clk cycles per digit slot, must be > BLANK_CYC
//  BLANK_CYC    500    cycles at slot start with all anodes off (ghost guard), >= 1
//  LZ_SUPPRESS  1      1: blank leading zeros (digit 0 always shown); 0: show all
//  HEX_MODE     0      0: codes 0-9 digits, 10 minus, 11-15 blank; 1: 10-15 show A,b,C,d,E,F
// PORTS
//  clk         in   1          system clock, all state on rising edge
//  rst         in   1          synchronous, active-high reset
//  data        in   4*DIGITS   digit codes, data[4k+3:4k] = digit k (k=0 rightmost)
//  dp_in       in   DIGITS     decimal point request per digit, 1 = lit
//  blank       in   DIGITS     force digit k dark, 1 = dark
//  load        in   1          1-cycle strobe: capture data/dp_in/blank into pending buffer
//  seg         out  7          {a,b,c,d,e,f,g}, active low
//  dp          out  1          decimal point segment, active low
//  an          out  DIGITS     digit enables, active low, at most one low at any time
//  frame_done  out  1          1-cycle pulse at end of each full scan frame
// BEHAVIOUR
//  Reset: seg=7'b1111111, dp=1, an=all 1, frame_done=0; slot counter 0, digit index 0;
//   pending and display buffers = all zeros, dp 0, blank 0; pending_valid=0.
//  Buffers: load=1 -> pending <= {data,dp_in,blank}, pending_valid<=1; a later load before
//   transfer overwrites (last wins). Display buffer only updated at frame boundary.
//  Slot counter cnt runs 0..REFRESH_DIV-1 per digit; wrap advances idx 0..DIGITS-1..0.
//  Frame boundary = wrap from idx DIGITS-1: frame_done pulses that cycle; if pending_valid
//   (incl. a load in that same cycle, which wins) display <= pending, pending_valid<=0.
//  States per slot: BLANK (cnt < BLANK_CYC): an all 1, seg all 1, dp 1.
//   ON (cnt >= BLANK_CYC): an[idx]=0, seg=decode(display digit idx), dp=~dp_bit[idx].
//  Outputs registered: output at cycle t+1 reflects cnt/idx/display at cycle t.
//   After rst falls: BLANK_CYC+1 cycles all dark, then an[0]=0 for REFRESH_DIV-BLANK_CYC.
//  Digit k dark in ON (an[k] still 0, seg=7F, dp=1) if blank[k], or LZ_SUPPRESS and k>0
//   and digits k..DIGITS-1 all code 0. dp still honoured for suppressed zeros, not blank.
//  Decode (active low): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100
//   6=0100000 7=0001111 8=0000000 9=0000100; HEX_MODE=0: 10=1111110, 11-15=1111111;
//   HEX_MODE=1: A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
//  rst mid-slot/mid-frame: next cycle all outputs at reset values, scan restarts digit 0.
//  DIGITS=1: every slot wrap is a frame boundary; LZ never blanks the single digit.
// STRUCTURE
//  Package seg7_pkg: localparam segment codes (SEG_0..SEG_9, SEG_MINUS, SEG_A..SEG_F,
//   SEG_BLANK), function/width constants for digit code width (4) and segment width (7).
//  Sub-module seg7_hex_decode (comb, params HEX_MODE): 4-bit code -> 7-bit active-low seg.
//  Top: slot counter, digit index, pending/display buffers, LZ mask, output registers.
// TESTING (bench with REFRESH_DIV=8, BLANK_CYC=2, DIGITS=4)
//  Reset then idle -> an=1111 for 3 cycles, an=1110 seg=0000001 6 cycles, digits 1-3 dark.
//  load data=16'h1234 dp_in=4'b0100 -> after next frame_done digit3 seg=1001111 ...
//   digit0 seg=1001100, dp=0 only while an=1011.
//  data=16'h0050, LZ_SUPPRESS=1 -> digits 3,2 dark, digit1 0100100, digit0 0000001;
//   LZ_SUPPRESS=0 -> digit3/2 show 0000001.
//  HEX_MODE=0 data=16'hA_F_B_0 -> 1111110,1111111,1111111; HEX_MODE=1 -> 0001000,0111000,1100000.
//  Two loads mid-frame (16'h1111 then 16'h2222) -> no change until frame_done, then 2222;
//   load coincident with frame_done -> applied that boundary.
//  rst asserted while an=1101 -> next cycle an=1111 seg=7F, scan restarts at digit 0,
//   display shows zeros; check one-hot-low an every cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver.
// Segment patterns are active low, ordered {a,b,c,d,e,f,g}.
// seg_decode() maps a 4-bit digit code to its segment pattern; hex_mode selects
// whether codes 10..15 show A..F or the minus/blank set.
package seg7_pkg;

    localparam int CODE_W = 4;
    localparam int SEG_W  = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
    localparam logic [SEG_W-1:0] SEG_MINUS = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b1100000;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b0110001;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b1000010;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b0111000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_ON    = 1'b1
    } slot_phase_e;

    function automatic logic [SEG_W-1:0] seg_decode(input logic [CODE_W-1:0] code,
                                                     input logic              hex_mode);
        logic [SEG_W-1:0] s;
        case (code)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            4'd10:   s = hex_mode ? SEG_A : SEG_MINUS;
            4'd11:   s = hex_mode ? SEG_B : SEG_BLANK;
            4'd12:   s = hex_mode ? SEG_C : SEG_BLANK;
            4'd13:   s = hex_mode ? SEG_D : SEG_BLANK;
            4'd14:   s = hex_mode ? SEG_E : SEG_BLANK;
            4'd15:   s = hex_mode ? SEG_F : SEG_BLANK;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational digit-code to segment decoder.
// Ports:
//   code  in   4   digit code
//   seg   out  7   {a,b,c,d,e,f,g}, active low
// HEX_MODE=0: 10 is minus, 11..15 blank. HEX_MODE=1: 10..15 show A,b,C,d,E,F.
module seg7_hex_decode
    import seg7_pkg::*;
#(
    parameter int HEX_MODE = 0
) (
    input  logic [CODE_W-1:0] code,
    output logic [SEG_W-1:0]  seg
);

    localparam logic HEX_EN = (HEX_MODE != 0);

    always_comb begin
        seg = seg_decode(code, HEX_EN);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver with double-buffered frame,
// anti-ghosting blank gap, leading-zero suppression and decimal points.
// Ports:
//   clk         in   1          system clock
//   rst         in   1          synchronous active-high reset
//   data        in   4*DIGITS   digit codes, digit k at data[4k+3:4k], k=0 rightmost
//   dp_in       in   DIGITS     decimal point request per digit, 1 = lit
//   blank       in   DIGITS     force digit dark, 1 = dark
//   load        in   1          strobe: capture data/dp_in/blank into pending buffer
//   seg         out  7          {a,b,c,d,e,f,g}, active low
//   dp          out  1          decimal point, active low
//   an          out  DIGITS     digit enables, active low, at most one low
//   frame_done  out  1          pulse once per full scan frame
//
// Slot phase (derived from the slot timer):
//   phase    | meaning
//   PH_BLANK | first BLANK_CYC cycles of a slot, all anodes off
//   PH_ON    | rest of the slot, anode idx on, segments from display buffer
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500,
    parameter int LZ_SUPPRESS = 1,
    parameter int HEX_MODE    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CODE_W*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]          dp_in,
    input  logic [DIGITS-1:0]          blank,
    input  logic                       load,
    output logic [SEG_W-1:0]           seg,
    output logic                       dp,
    output logic [DIGITS-1:0]          an,
    output logic                       frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Slot timer counts down; elapsed count = TMR_LOAD - tmr, so the ON phase
    // starts once tmr has fallen to ON_TMR.
    localparam logic [CNT_W-1:0] TMR_LOAD = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] ON_TMR   = CNT_W'(REFRESH_DIV - 1 - BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]          tmr;
    logic [IDX_W-1:0]          idx;
    logic                      slot_end;
    logic                      frame_end;
    slot_phase_e               phase;

    logic [CODE_W*DIGITS-1:0]  pend_data;
    logic [DIGITS-1:0]         pend_dp;
    logic [DIGITS-1:0]         pend_blank;
    logic                      pend_valid;
    logic [CODE_W*DIGITS-1:0]  disp_data;
    logic [DIGITS-1:0]         disp_dp;
    logic [DIGITS-1:0]         disp_blank;

    logic [DIGITS-1:0]         lz_dark;
    logic [CODE_W-1:0]         cur_code;
    logic                      cur_dp;
    logic                      cur_blank;
    logic                      cur_lz;
    logic [SEG_W-1:0]          dec_seg;

    logic [SEG_W-1:0]          seg_nxt;
    logic                      dp_nxt;
    logic [DIGITS-1:0]         an_nxt;

    assign slot_end  = (tmr == '0);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign phase     = (tmr <= ON_TMR) ? PH_ON : PH_BLANK;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr <= TMR_LOAD;
            idx <= '0;
        end else if (slot_end) begin
            tmr <= TMR_LOAD;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            tmr <= tmr - 1'b1;
        end
    end

    // A load landing on the frame boundary goes straight to the display buffer
    // and leaves nothing pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
            disp_data  <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
        end else begin
            if (load) begin
                pend_data  <= data;
                pend_dp    <= dp_in;
                pend_blank <= blank;
                pend_valid <= 1'b1;
            end
            if (frame_end) begin
                if (load) begin
                    disp_data  <= data;
                    disp_dp    <= dp_in;
                    disp_blank <= blank;
                    pend_valid <= 1'b0;
                end else if (pend_valid) begin
                    disp_data  <= pend_data;
                    disp_dp    <= pend_dp;
                    disp_blank <= pend_blank;
                    pend_valid <= 1'b0;
                end
            end
        end
    end

    // Digit k is a leading zero when it and every digit to its left are zero.
    // Digit 0 is never suppressed.
    always_comb begin
        logic run;
        lz_dark = '0;
        run     = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run        = run & (disp_data[CODE_W*k +: CODE_W] == '0);
            lz_dark[k] = (LZ_SUPPRESS != 0) && run;
        end
    end

    always_comb begin
        cur_code  = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_lz    = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_code  = disp_data[CODE_W*k +: CODE_W];
                cur_dp    = disp_dp[k];
                cur_blank = disp_blank[k];
                cur_lz    = lz_dark[k];
            end
        end
    end

    seg7_hex_decode #(
        .HEX_MODE (HEX_MODE)
    ) u_dec (
        .code (cur_code),
        .seg  (dec_seg)
    );

    // Suppressed zeros keep their decimal point; forced-blank digits lose it.
    always_comb begin
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b1;
        an_nxt  = '1;
        if (phase == PH_ON) begin
            for (int k = 0; k < DIGITS; k++) begin
                an_nxt[k] = (idx != IDX_W'(k));
            end
            if (!cur_blank) begin
                dp_nxt = ~cur_dp;
                if (!cur_lz) begin
                    seg_nxt = dec_seg;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            an         <= an_nxt;
            frame_done <= frame_end;
        end
    end

endmodule
